// File: rtl/rand_seg_pkg.sv
// Shared constants for the random ROM-segment selector: LFSR geometry,
// default seed, FSM encoding and ROM segment layout.
package rand_seg_pkg;

  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned TAP_A   = 16;
  localparam int unsigned TAP_B   = 14;
  localparam int unsigned TAP_C   = 13;
  localparam int unsigned TAP_D   = 11;

  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

  localparam int unsigned SEG_COUNT = 4;
  localparam int unsigned SEG_SEL_W = 2;
  localparam int unsigned SEG_SIZE  = 256;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DWELL    = 2'd1;
  localparam logic [1:0] ST_WAIT_BND = 2'd2;

  // Right-shifting Fibonacci step; tap t maps to bit (LFSR_W - t).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[LFSR_W-TAP_A] ^ l[LFSR_W-TAP_B] ^ l[LFSR_W-TAP_C] ^ l[LFSR_W-TAP_D];
    return {fb, l[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with seed load (priority over shift) and a guard
// that replaces an all-zero seed with the default seed.
module lfsr16
  import rand_seg_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (load_val == '0) ? SEED : load_val;
    end else if (en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/rand_seg_sel.sv
// Picks the next ROM segment from the LFSR after a programmable dwell and
// commits it only on the address generator's segment wrap.
module rand_seg_sel
  import rand_seg_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED      = SEED_DEFAULT,
  parameter int unsigned       DWELL_W   = 16,
  parameter bit                NO_REPEAT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed_in,
  input  logic [DWELL_W-1:0]   dwell_len,
  input  logic                 seg_done,
  output logic [SEG_SEL_W-1:0] seg_sel,
  output logic                 seg_valid,
  output logic [LFSR_W-1:0]    lfsr_out
);

  logic [1:0]           state_d, state_q;
  logic [DWELL_W-1:0]   cnt_d, cnt_q;
  logic [SEG_SEL_W-1:0] cand_r_d, cand_r_q;
  logic [SEG_SEL_W-1:0] seg_sel_d, seg_sel_q;
  logic                 seg_valid_d, seg_valid_q;

  logic [LFSR_W-1:0]    lfsr_q;
  logic [SEG_SEL_W-1:0] cand_c;
  logic [DWELL_W-1:0]   reload_c;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (lfsr_q)
  );

  // Candidate from LFSR bits [4:3], bumped by one if it would repeat.
  always_comb begin
    cand_c = lfsr_q[4:3];
    if (NO_REPEAT && (cand_c == seg_sel_q)) begin
      cand_c = SEG_SEL_W'(cand_c + SEG_SEL_W'(1));
    end
  end

  // A zero dwell is treated as one cycle.
  assign reload_c = (dwell_len == '0) ? '0 : DWELL_W'(dwell_len - DWELL_W'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_r_d    = cand_r_q;
    seg_sel_d   = seg_sel_q;
    seg_valid_d = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d   = reload_c;
          state_d = ST_DWELL;
        end
        ST_DWELL: begin
          if (cnt_q != '0) begin
            cnt_d = DWELL_W'(cnt_q - DWELL_W'(1));
          end else if (seg_done) begin
            seg_sel_d   = cand_c;
            seg_valid_d = 1'b1;
            cnt_d       = reload_c;
          end else begin
            cand_r_d = cand_c;
            state_d  = ST_WAIT_BND;
          end
        end
        ST_WAIT_BND: begin
          if (seg_done) begin
            seg_sel_d   = cand_r_q;
            seg_valid_d = 1'b1;
            cnt_d       = reload_c;
            state_d     = ST_DWELL;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_r_q    <= '0;
      seg_sel_q   <= '0;
      seg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_r_q    <= cand_r_d;
      seg_sel_q   <= seg_sel_d;
      seg_valid_q <= seg_valid_d;
    end
  end

  assign seg_sel   = seg_sel_q;
  assign seg_valid = seg_valid_q;
  assign lfsr_out  = lfsr_q;

endmodule

// File: tb/tb_rand_seg_sel.sv
// Directed bench for rand_seg_sel: a cycle-level behavioural model checked
// every cycle, plus hand-computed literal expectations.
module tb_rand_seg_sel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [15:0] dwell_len;
  logic        seg_done;
  logic [1:0]  seg_sel;
  logic        seg_valid;
  logic [15:0] lfsr_out;

  int tests_run = 0;
  int tests_failed = 0;

  rand_seg_sel dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .dwell_len (dwell_len),
    .seg_done  (seg_done),
    .seg_sel   (seg_sel),
    .seg_valid (seg_valid),
    .lfsr_out  (lfsr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_lfsr;
  logic [1:0]  m_sel;
  logic        m_valid;
  bit          m_active;   // enabled and dwell timing started
  bit          m_pending;  // dwell over, choice waiting for a boundary
  logic [1:0]  m_cand;
  int          m_elapsed;  // dwell cycles already spent since last reload
  int          m_dwell;

  function automatic logic [15:0] step16(input logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  function automatic logic [1:0] pick(input logic [15:0] l, input logic [1:0] cur);
    int c;
    c = (l >> 3) & 3;
    if (c == int'(cur)) c = (c + 1) % 4;
    return 2'(c);
  endfunction

  function automatic int dwell_of(input logic [15:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] old_l;
    logic [1:0]  c;
    if (!rst_n) begin
      m_lfsr = 16'hACE1; m_sel = 0; m_valid = 0;
      m_active = 0; m_pending = 0; m_cand = 0; m_elapsed = 0; m_dwell = 1;
    end else begin
      old_l = m_lfsr;
      if (seed_load) m_lfsr = (seed_in == 0) ? 16'hACE1 : seed_in;
      else if (en) m_lfsr = step16(m_lfsr);
      m_valid = 0;
      if (!en) begin
        m_active = 0; m_pending = 0;
      end else if (!m_active) begin
        m_active = 1; m_elapsed = 0; m_dwell = dwell_of(dwell_len);
      end else if (m_pending || m_elapsed == m_dwell - 1) begin
        c = m_pending ? m_cand : pick(old_l, m_sel);
        if (seg_done) begin
          m_sel = c; m_valid = 1; m_pending = 0;
          m_elapsed = 0; m_dwell = dwell_of(dwell_len);
        end else begin
          m_pending = 1; m_cand = c;
        end
      end else begin
        m_elapsed++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model_seg_sel", 32'(seg_sel), 32'(m_sel));
      check("model_seg_valid", 32'(seg_valid), 32'(m_valid));
      check("model_lfsr", 32'(lfsr_out), 32'(m_lfsr));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit          nonzero;
    bit          last_done;
    bit          differ_ok;
    int          commits;
    int          first_v;
    logic [1:0]  prev_sel;
    logic [1:0]  held_sel;
    bit          saw_valid;

    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_in = '0;
    dwell_len = 16'd4; seg_done = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_seg_sel", 32'(seg_sel), 32'h0);
    check("rst_seg_valid", 32'(seg_valid), 32'h0);
    check("rst_lfsr", 32'(lfsr_out), 32'hACE1);
    rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    check("lfsr_step1", 32'(lfsr_out), 32'h5670);
    @(negedge clk);
    check("lfsr_step2", 32'(lfsr_out), 32'hAB38);

    // Zero seed falls back to default; full period
    seed_load = 1'b1; seed_in = 16'h0000;
    @(negedge clk);
    seed_load = 1'b0;
    check("zero_seed_load", 32'(lfsr_out), 32'hACE1);
    nonzero = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      if (lfsr_out == 16'h0) nonzero = 1'b0;
      if (i < 65534 && lfsr_out == 16'hACE1) nonzero = 1'b0;
    end
    check("lfsr_period_no_early_repeat_or_zero", 32'(nonzero), 32'h1);
    check("lfsr_period_return", 32'(lfsr_out), 32'hACE1);

    // Short dwell, boundary every 256 cycles
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; dwell_len = 16'd4;
    commits = 0; last_done = 1'b0; differ_ok = 1'b1; prev_sel = seg_sel;
    for (int i = 0; i < 6 * 256 + 2; i++) begin
      if (i > 0 && seg_valid) begin
        commits++;
        check("valid_follows_seg_done", 32'(last_done), 32'h1);
        if (seg_sel == prev_sel) differ_ok = 1'b0;
        prev_sel = seg_sel;
      end
      seg_done = ((i % 256) == 255);
      last_done = seg_done;
      @(negedge clk);
    end
    seg_done = 1'b0;
    check("short_dwell_commits", 32'(commits), 32'd6);
    check("no_repeat_commits", 32'(differ_ok), 32'h1);

    // Long dwell: first commit one cycle after the boundary at 1023
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; dwell_len = 16'd1000; first_v = -1;
    for (int j = 0; j <= 1100; j++) begin
      if (j > 0 && seg_valid && first_v < 0) first_v = j;
      seg_done = ((j % 256) == 255);
      @(negedge clk);
    end
    seg_done = 1'b0;
    check("long_dwell_first_commit", 32'(first_v), 32'd1024);

    // Drop en while waiting for the boundary
    en = 1'b0;
    @(negedge clk);
    en = 1'b1; dwell_len = 16'd4;
    repeat (10) @(negedge clk);
    held_sel = seg_sel;
    en = 1'b0;
    @(negedge clk);
    seg_done = 1'b1;
    saw_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (seg_valid) saw_valid = 1'b1;
    end
    seg_done = 1'b0;
    check("en_drop_no_valid", 32'(saw_valid), 32'h0);
    check("en_drop_sel_hold", 32'(seg_sel), 32'(held_sel));

    // Re-enable: full dwell of 8 before a commit even with seg_done held high
    dwell_len = 16'd8; en = 1'b1; seg_done = 1'b1; first_v = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (seg_valid && first_v < 0) first_v = k;
    end
    seg_done = 1'b0;
    check("dwell_restart_first_commit", 32'(first_v), 32'd9);

    // Asynchronous reset mid-dwell
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg_sel", 32'(seg_sel), 32'h0);
    check("async_rst_seg_valid", 32'(seg_valid), 32'h0);
    check("async_rst_lfsr", 32'(lfsr_out), 32'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
